// File: rtl/otter_csr_pkg.sv
// otter_csr_pkg: CSR addresses, mcause code and mstatus bit positions shared by the interrupt responder.
package otter_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
endpackage

// File: rtl/intr_sync.sv
// intr_sync: multi-stage synchronizer for the external interrupt line with a rising-edge pulse.
module intr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync, valid;
  logic hist;
  // hist is held high until the chain carries real samples, so a line already high out of reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      valid <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      valid <= {valid[STAGES-2:0], 1'b1};
      hist <= valid[STAGES-1] ? sync[STAGES-1] : 1'b1;
    end
  end
  assign level = sync[STAGES-1];
  assign rise = valid[STAGES-1] & level & ~hist;
endmodule

// File: rtl/otter_csr_intr.sv
// otter_csr_intr: machine-mode CSRs and interrupt responder; define OTTER_INTR_EDGE_EN for edge-latched pending, else level mode.
import otter_csr_pkg::*;
module otter_csr_intr #(
  parameter int SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr_in,
  output logic        intr,
  input  logic        csr_WE,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  output logic [31:0] csr_rd,
  input  logic        int_taken,
  input  logic        mret_exec,
  input  logic [31:0] pc,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        mie
);
  logic level, rise, pending, mie_q, mpie_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q, mstatus;
  intr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .din(intr_in),
    .level(level),
    .rise(rise)
  );
`ifdef OTTER_INTR_EDGE_EN
  logic pend_q;
  // a new edge beats the entry clear so it is never lost
  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else if (rise) pend_q <= 1'b1;
    else if (int_taken) pend_q <= 1'b0;
  end
  assign pending = pend_q;
`else
  logic unused_rise;
  assign unused_rise = rise;
  assign pending = level;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      mtvec_q <= MTVEC_RST & ~32'd3;
      mepc_q <= '0;
      mcause_q <= '0;
    end else if (int_taken) begin
      mepc_q <= pc & ~32'd3;
      mcause_q <= MCAUSE_EXT_INT;
      mpie_q <= mie_q;
      mie_q <= 1'b0;
    end else if (mret_exec) begin
      mie_q <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_WE) begin
      if (csr_addr == CSR_MSTATUS) begin
        mie_q <= csr_wd[MSTATUS_MIE];
        mpie_q <= csr_wd[MSTATUS_MPIE];
      end
      if (csr_addr == CSR_MTVEC) mtvec_q <= csr_wd & ~32'd3;
      if (csr_addr == CSR_MEPC) mepc_q <= csr_wd & ~32'd3;
      if (csr_addr == CSR_MCAUSE) mcause_q <= csr_wd;
    end
  end
  always_comb begin
    mstatus = '0;
    mstatus[MSTATUS_MIE] = mie_q;
    mstatus[MSTATUS_MPIE] = mpie_q;
  end
  assign csr_rd = (csr_addr == CSR_MSTATUS) ? mstatus :
                  (csr_addr == CSR_MTVEC)   ? mtvec_q :
                  (csr_addr == CSR_MEPC)    ? mepc_q :
                  (csr_addr == CSR_MCAUSE)  ? mcause_q : 32'h0;
  assign intr = pending & mie_q;
  assign mie = mie_q;
  assign mtvec = mtvec_q;
  assign mepc = mepc_q;
endmodule

// File: tb/tb_otter_csr_intr.sv
// tb_otter_csr_intr: directed and random checks of otter_csr_intr against a sample-history reference model.
module tb_otter_csr_intr;
  localparam int S = 2;
  localparam logic [31:0] MT = 32'h0000_0207;
`ifdef OTTER_INTR_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic clk = 0, rst = 1, intr_in = 0, csr_WE = 0, int_taken = 0, mret_exec = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_wd = 0, pc = 0;
  logic intr, mie;
  logic [31:0] csr_rd, mtvec, mepc;
  int checks = 0, errors = 0;
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  bit m_pend;
  bit q[$];
  otter_csr_intr #(.SYNC_STAGES(S), .MTVEC_RST(MT)) dut (
    .clk(clk), .rst(rst), .intr_in(intr_in), .intr(intr), .csr_WE(csr_WE),
    .csr_addr(csr_addr), .csr_wd(csr_wd), .csr_rd(csr_rd), .int_taken(int_taken),
    .mret_exec(mret_exec), .pc(pc), .mtvec(mtvec), .mepc(mepc), .mie(mie)
  );
  always #5 clk = ~clk;
  // synchronized level after the k-th post-reset edge is the sample taken S-1 edges earlier
  function automatic bit lvl(int k);
    return (k - S >= 0) ? q[k-S] : 1'b0;
  endfunction
  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction
  function automatic bit m_intr();
    return (EDGE ? m_pend : lvl(q.size())) & m_mstatus[3];
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    int n;
    bit rise;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pend = 0;
      m_mstatus = 0;
      m_mepc = 0;
      m_mcause = 0;
      m_mtvec = MT & ~32'd3;
    end else begin
      n = q.size();
      rise = EDGE && (n - 1 >= S) && lvl(n) && !lvl(n - 1);
      if (int_taken) begin
        m_mepc = pc & ~32'd3;
        m_mcause = 32'h8000_000B;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end else if (mret_exec) begin
        m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
      end else if (csr_WE) begin
        case (csr_addr)
          12'h300: m_mstatus = csr_wd & 32'h88;
          12'h305: m_mtvec = csr_wd & ~32'd3;
          12'h341: m_mepc = csr_wd & ~32'd3;
          12'h342: m_mcause = csr_wd;
          default: ;
        endcase
      end
      m_pend = rise ? 1'b1 : (int_taken ? 1'b0 : m_pend);
      q.push_back(intr_in);
    end
    #1;
    chk("intr", intr, m_intr());
    chk("mie", mie, m_mstatus[3]);
    chk("mtvec", mtvec, m_mtvec);
    chk("mepc", mepc, m_mepc);
    chk("csr_rd", csr_rd, m_read(csr_addr));
    csr_WE = 0;
    int_taken = 0;
    mret_exec = 0;
  endtask
  task automatic wr(logic [11:0] a, logic [31:0] d);
    csr_WE = 1;
    csr_addr = a;
    csr_wd = d;
    tick();
  endtask
  task automatic rd_chk(string tag, logic [11:0] a, logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rd, exp);
  endtask
  initial begin
    int e;
    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h001};
    rst = 1;
    tick();
    tick();
    rst = 0;
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mtvec", 12'h305, 32'h0000_0204);
    rd_chk("rst_mepc", 12'h341, 32'h0);
    rd_chk("rst_mcause", 12'h342, 32'h0);
    chk("rst_intr", intr, 0);
    wr(12'h305, 32'h0000_0103);
    rd_chk("mtvec_align", 12'h305, 32'h0000_0100);
    wr(12'h7C0, 32'hFFFF_FFFF);
    rd_chk("unimpl_rd", 12'h7C0, 32'h0);
    rd_chk("unimpl_no_side", 12'h305, 32'h0000_0100);
    repeat (4) tick();
    wr(12'h300, 32'h8);
    intr_in = 1;
    tick();
    intr_in = 0;
    e = 1;
    while (!intr && e < 20) begin
      tick();
      e++;
    end
    chk("intr_latency", e, EDGE ? S + 1 : S);
    int_taken = 1;
    pc = 32'h0000_0044;
    tick();
    rd_chk("entry_mepc", 12'h341, 32'h44);
    rd_chk("entry_mcause", 12'h342, 32'h8000_000B);
    rd_chk("entry_mstatus", 12'h300, 32'h80);
    chk("entry_intr", intr, 0);
    mret_exec = 1;
    tick();
    rd_chk("mret_mstatus", 12'h300, 32'h88);
    wr(12'h300, 32'h0);
    intr_in = 1;
    tick();
    intr_in = 0;
    repeat (6) tick();
    chk("held_intr", intr, 0);
    wr(12'h300, 32'h8);
    chk("held_release", intr, EDGE);
    int_taken = 1;
    mret_exec = 1;
    csr_WE = 1;
    csr_addr = 12'h300;
    csr_wd = 32'h0;
    pc = 32'h0000_1234;
    tick();
    rd_chk("prio_mstatus", 12'h300, 32'h80);
    rd_chk("prio_mepc", 12'h341, 32'h1234);
    wr(12'h300, 32'h8);
    intr_in = 1;
    repeat (S + 3) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_pend_intr", intr, 0);
    wr(12'h300, 32'h8);
    repeat (8) tick();
    chk("rst_no_retrig", intr, !EDGE);
    intr_in = 0;
    repeat (4) tick();
    intr_in = 1;
    repeat (S + 2) tick();
    chk("retrig_intr", intr, 1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) intr_in = ~intr_in;
      csr_addr = addrs[$urandom_range(0, 5)];
      csr_wd = $urandom;
      csr_WE = ($urandom_range(0, 3) == 0);
      if (csr_addr == 12'h300 && $urandom_range(0, 1) == 1) csr_wd = 32'h8;
      int_taken = (intr && $urandom_range(0, 1) == 1) || ($urandom_range(0, 19) == 0);
      mret_exec = ($urandom_range(0, 9) == 0);
      pc = $urandom;
      tick();
    end
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/otter_csr_intr.md
# otter_csr_intr

Machine-mode CSR file and interrupt responder for the OTTER multicycle core. It is the other end of the control unit's `csr_WE` / `int_taken` / `mret_exec` / `intr` handshake. It synchronizes the external interrupt line, holds it pending, and presents a gated request to the control FSM. On interrupt entry and `mret` it updates mstatus/mepc/mcause, and it supplies mtvec/mepc to the PC source mux.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `intr_in`, minimum 2.
- `MTVEC_RST`, default 32'h0: reset value of mtvec; bits [1:0] are ignored.

Ports:
- `clk` in 1: core clock, the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `intr_in` in 1: external interrupt line, asynchronous.
- `intr` out 1: interrupt request to the control FSM.
- `csr_WE` in 1: CSR write strobe from the control FSM.
- `csr_addr` in 12: CSR address, IR[31:20].
- `csr_wd` in 32: CSR write data, already computed by the datapath.
- `csr_rd` out 32: CSR read data, combinational from `csr_addr`.
- `int_taken` in 1: interrupt-entry pulse from the control FSM.
- `mret_exec` in 1: mret pulse from the control FSM.
- `pc` in 32: PC value saved into mepc on entry.
- `mtvec` out 32: trap vector to the PC mux.
- `mepc` out 32: return address to the PC mux.
- `mie` out 1: mstatus.MIE.

## Operation
- Implemented CSRs:
  - mstatus 0x300: bit 3 is MIE, bit 7 is MPIE; all other bits read 0 and ignore writes.
  - mtvec 0x305.
  - mepc 0x341.
  - mcause 0x342.
- Unimplemented addresses read 32'h0; writes to them are ignored with no error.
- A write of `csr_wd` lands at the `clk` edge where `csr_WE`=1.
- mtvec[1:0] and mepc[1:0] are forced to 0 on every write (direct mode, word-aligned).
- Interrupt entry (`int_taken`=1 at the edge):
  - mepc ← {pc[31:2],2'b00}
  - mcause ← 32'h8000_000B
  - MPIE ← MIE, MIE ← 0
  - pending ← 0
- Return (`mret_exec`=1 at the edge): MIE ← MPIE, MPIE ← 1.
- Simultaneous events:
  - Priority is `int_taken` > `mret_exec` > `csr_WE`. Only the highest-priority update applies to CSR state.
  - If a pending-set and an `int_taken` clear happen on the same edge, the set wins, so no edge is lost.
- `intr` = pending & MIE, driven from registered state only.
- Reset values:
  - mstatus = 0, mepc = 0, mcause = 0, mtvec = MTVEC_RST & ~3.
  - Synchronizer flops = 0, edge-history flop = 0, pending = 0.
  - Outputs: `intr`=0, `mie`=0, `mtvec`=MTVEC_RST & ~3, `mepc`=0.
- Reset mid-sequence: any pending interrupt is discarded. An `intr_in` still high after reset does not re-trigger in edge mode; the edge-history flop must see a 0 first.

## Timing
- CSR read: combinational, valid in the same cycle as `csr_addr`.
- CSR write, entry and mret: visible on outputs one cycle after the edge.
- Edge mode:
  - `intr_in` rises before edge k.
  - Synchronizer output is high after edge k+SYNC_STAGES-1.
  - pending sets and `intr` asserts (if MIE=1) after edge k+SYNC_STAGES.
- Level mode: `intr` asserts after edge k+SYNC_STAGES-1 and tracks the synchronized level.
- If MIE=0, pending is held and `intr` asserts one cycle after the MIE write lands.

## Configuration
- `OTTER_INTR_EDGE_EN` defined (edge mode):
  - pending sets on a synchronized rising edge.
  - pending clears only on `int_taken`.
  - A pulse of one or more cycles is never lost while MIE=0.
- `OTTER_INTR_EDGE_EN` undefined (level mode):
  - No pending latch; pending = synchronized `intr_in`.
  - `int_taken` has no clearing effect, so the device must deassert its line.

## Structure
- Package `otter_csr_pkg` holds:
  - Address localparams: CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE.
  - MCAUSE_EXT_INT = 32'h8000_000B.
  - Bit indices MSTATUS_MIE = 3 and MSTATUS_MPIE = 7.
- Sub-module `intr_sync`: holds the parameterized synchronizer chain plus the rising-edge detector. It outputs the synchronized level and a one-cycle edge pulse. The pending latch and its macro select stay in the top module.

## Test plan
- Reset, then read 0x300, 0x305, 0x341, 0x342 → 0, MTVEC_RST&~3, 0, 0; `intr`=0.
- Write 0x305 ← 32'h0000_0103 → reads 32'h0000_0100. Write 0x7C0 ← 32'hFFFF_FFFF → reads 0 and no CSR changes.
- mstatus ← 8, then 1-cycle `intr_in` pulse (edge mode) → `intr`=1 exactly SYNC_STAGES+1 edges after the rise. Then `int_taken` with pc=32'h0000_0044 → mepc=32'h44, mcause=32'h8000_000B, mstatus=32'h80, `intr`=0.
- From the last state, `mret_exec` → mstatus=32'h88. A second `intr_in` pulse while MIE=0 → pending held, `intr` rises one cycle after mstatus ← 8.
- `int_taken`, `mret_exec` and `csr_WE` (to mstatus, data 0) on the same edge → entry result only (mstatus=32'h80).
- `rst` asserted while pending=1 and `intr_in` held high → `intr`=0 after reset and stays 0 in edge mode until `intr_in` falls and rises again.
